// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ack data bus between the MEM-stage LSU (master) and memory (slave).
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit; stalls the pipeline while a load/store completes over a req/ack bus.
module mem_stage_lsu #(
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [2:0]             funct3_i,
    input  logic [31:0]            alu_out_i,
    input  logic [31:0]            rs2_data_i,
    output logic                   stall_o,
    output logic [31:0]            load_data_o,
    output logic                   load_valid_o,
    output logic                   misalign_o,
    output logic                   bus_err_o,
    mem_stage_lsu_if.master        bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic          lv_q, lv_d, mis_q, mis_d, err_q, err_d;
    logic          req, illegal, timeout;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new, lane, ext;

    assign req = mem_read_i | mem_write_i;
    assign illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (mem_write_i && funct3_i[2])
                   || (funct3_i[1:0] == 2'b01 && alu_out_i[0])
                   || (funct3_i[1:0] == 2'b10 && alu_out_i[1:0] != 2'b00);
    assign be_new = !mem_write_i ? 4'b1111 :
                    funct3_i[1:0] == 2'b00 ? 4'b0001 << alu_out_i[1:0] :
                    funct3_i[1:0] == 2'b01 ? (alu_out_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_new = !mem_write_i ? 32'h0 :
                       funct3_i[1:0] == 2'b00 ? {4{rs2_data_i[7:0]}} :
                       funct3_i[1:0] == 2'b01 ? {2{rs2_data_i[15:0]}} : rs2_data_i;
    assign lane = bus.rdata >> {addr_q[1:0], 3'b000};
    assign ext = f3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                 f3_q == 3'b100 ? {24'h0, lane[7:0]} :
                 f3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                 f3_q == 3'b101 ? {16'h0, lane[15:0]} : lane;
    assign timeout = cnt_q == CW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        ld_d    = ld_q;
        lv_d    = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        stall_o = 1'b0;
        bus.req = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !illegal) begin
                    we_d    = mem_write_i;
                    addr_d  = alu_out_i;
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    f3_d    = funct3_i;
                    stall_o = 1'b1;
                    state_d = WAIT;
                end
                mis_d = req && illegal;
            end
            WAIT: begin
                bus.req = 1'b1;
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (bus.ack) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    lv_d    = !we_q;
                    ld_d    = we_q ? ld_q : ext;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    err_d   = 1'b1;
                    ld_d    = 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            f3_q    <= 3'h0;
            ld_q    <= 32'h0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            ld_q    <= ld_d;
            lv_q    <= lv_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign bus.we       = we_q;
    assign bus.addr     = {addr_q[31:2], 2'b00};
    assign bus.wdata    = wdata_q;
    assign bus.be       = be_q;
    assign load_data_o  = ld_q;
    assign load_valid_o = lv_q;
    assign misalign_o   = mis_q;
    assign bus_err_o    = err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed tests of the MEM-stage LSU with hand-computed expectations.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] alu_out = 32'h0, rs2_data = 32'h0;
    logic        stall, load_valid, misalign, bus_err;
    logic [31:0] load_data;
    int          errors = 0, checks = 0;
    int          stalls;
    logic        s_we, d_lv, d_err, d_stall, hung;
    logic [31:0] s_addr, s_wdata, d_ld;
    logic [3:0]  s_be;

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .funct3_i(funct3), .alu_out_i(alu_out), .rs2_data_i(rs2_data),
        .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
        .misalign_o(misalign), .bus_err_o(bus_err), .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access, ack after `delay` WAIT cycles (negative = never), record what was seen.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdata, input int delay);
        mem_read = rd; mem_write = wr; funct3 = f3; alu_out = a; rs2_data = wd;
        bus_if.rdata = rdata;
        hung = 1'b0;
        #1;
        stalls = stall ? 1 : 0;
        step();
        s_we = bus_if.we; s_addr = bus_if.addr; s_be = bus_if.be; s_wdata = bus_if.wdata;
        for (int i = 0; i < 40; i++) begin
            if (!bus_if.req) break;
            if (i == 39) hung = 1'b1;
            stalls += stall ? 1 : 0;
            bus_if.ack = (i == delay);
            step();
            bus_if.ack = 1'b0;
        end
        d_lv = load_valid; d_ld = load_data; d_err = bus_err; d_stall = stall;
        mem_read = 1'b0; mem_write = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if ({stall, load_valid, misalign, bus_err, bus_if.req, bus_if.we} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=000000", {stall, load_valid, misalign, bus_err, bus_if.req, bus_if.we}); end
        checks++; if ({load_data, bus_if.addr, bus_if.wdata, bus_if.be} !== 100'h0) begin errors++; $display("FAIL reset_data got=%h want=0", {load_data, bus_if.addr, bus_if.wdata, bus_if.be}); end
    endtask

    task automatic test_lw();
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checks++; if (stalls !== 2) begin errors++; $display("FAIL lw_stalls got=%0d want=2", stalls); end
        checks++; if ({s_addr, s_be, s_we} !== {32'h100, 4'hF, 1'b0}) begin errors++; $display("FAIL lw_bus got=%h/%h/%b want=100/f/0", s_addr, s_be, s_we); end
        checks++; if ({d_lv, d_stall, d_err, hung} !== 4'b1000) begin errors++; $display("FAIL lw_done got=%b want=1000", {d_lv, d_stall, d_err, hung}); end
        checks++; if (d_ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h want=deadbeef", d_ld); end
        checks++; if ({load_valid, load_data} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_hold got=%b/%h want=0/deadbeef", load_valid, load_data); end
    endtask

    task automatic test_loads_ext();
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
        checks++; if (stalls !== 3) begin errors++; $display("FAIL lb_stalls got=%0d want=3", stalls); end
        checks++; if ({d_lv, d_ld} !== {1'b1, 32'hFFFFFF80}) begin errors++; $display("FAIL lb got=%b/%h want=1/ffffff80", d_lv, d_ld); end
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
        checks++; if ({d_lv, d_ld} !== {1'b1, 32'h00000080}) begin errors++; $display("FAIL lbu got=%b/%h want=1/00000080", d_lv, d_ld); end
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2);
        checks++; if ({stalls, d_ld} !== {32'd4, 32'hFFFF8001}) begin errors++; $display("FAIL lh got=%0d/%h want=4/ffff8001", stalls, d_ld); end
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0);
        checks++; if (d_ld !== 32'h00008001) begin errors++; $display("FAIL lhu got=%h want=00008001", d_ld); end
        run_access(1, 0, 3'b001, 32'h100, 32'h0, 32'h80017FFF, 0);
        checks++; if (d_ld !== 32'h00007FFF) begin errors++; $display("FAIL lh_lo got=%h want=00007fff", d_ld); end
    endtask

    task automatic test_stores();
        run_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0);
        checks++; if ({s_we, s_be, s_wdata, s_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h200}) begin errors++; $display("FAIL sh got=%b/%b/%h/%h want=1/1100/abcdabcd/200", s_we, s_be, s_wdata, s_addr); end
        checks++; if ({d_lv, load_data} !== {1'b0, 32'h00007FFF}) begin errors++; $display("FAIL sh_keep got=%b/%h want=0/00007fff", d_lv, load_data); end
        run_access(1, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0);
        checks++; if ({s_we, s_be, s_wdata} !== {1'b1, 4'b0010, 32'h78787878}) begin errors++; $display("FAIL sb got=%b/%b/%h want=1/0010/78787878", s_we, s_be, s_wdata); end
        run_access(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1);
        checks++; if ({s_be, s_wdata, stalls} !== {4'hF, 32'hCAFEF00D, 32'd3}) begin errors++; $display("FAIL sw got=%h/%h/%0d want=f/cafef00d/3", s_be, s_wdata, stalls); end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] ads [4] = '{32'h101, 32'h103, 32'h100, 32'h100};
        logic        wrs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            mem_read = !wrs[i]; mem_write = wrs[i]; funct3 = f3s[i]; alu_out = ads[i];
            #1;
            checks++; if ({stall, bus_if.req} !== 2'b00) begin errors++; $display("FAIL mis%0d_issue got=%b want=00", i, {stall, bus_if.req}); end
            step();
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            checks++; if ({misalign, bus_if.req, stall} !== 3'b100) begin errors++; $display("FAIL mis%0d_pulse got=%b want=100", i, {misalign, bus_if.req, stall}); end
            step();
            checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis%0d_clear got=%b want=0", i, misalign); end
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, -1);
        checks++; if (stalls !== 16) begin errors++; $display("FAIL to_stalls got=%0d want=16", stalls); end
        checks++; if ({d_err, d_lv, d_stall, hung} !== 4'b1000) begin errors++; $display("FAIL to_done got=%b want=1000", {d_err, d_lv, d_stall, hung}); end
        checks++; if ({bus_err, bus_if.req, load_data} !== {2'b00, 32'h0}) begin errors++; $display("FAIL to_after got=%b/%b/%h want=0/0/0", bus_err, bus_if.req, load_data); end
    endtask

    task automatic test_back_to_back();
        run_access(1, 0, 3'b010, 32'h500, 32'h0, 32'h11223344, 0);
        run_access(1, 0, 3'b000, 32'h501, 32'h0, 32'h11223344, 0);
        checks++; if ({d_lv, d_ld} !== {1'b1, 32'h00000033}) begin errors++; $display("FAIL b2b got=%b/%h want=1/00000033", d_lv, d_ld); end
    endtask

    task automatic test_reset_mid_wait();
        mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h600; bus_if.rdata = 32'h55555555;
        step();
        checks++; if (bus_if.req !== 1'b1) begin errors++; $display("FAIL rmw_wait got=%b want=1", bus_if.req); end
        reset = 1'b1; mem_read = 1'b0;
        step();
        reset = 1'b0;
        bus_if.ack = 1'b1;
        #1;
        checks++; if ({bus_if.req, stall} !== 2'b00) begin errors++; $display("FAIL rmw_drop got=%b want=00", {bus_if.req, stall}); end
        step();
        bus_if.ack = 1'b0;
        checks++; if ({stall, load_valid, misalign, bus_err, bus_if.req, bus_if.we} !== 6'b0) begin errors++; $display("FAIL rmw_ctrl got=%b want=000000", {stall, load_valid, misalign, bus_err, bus_if.req, bus_if.we}); end
        checks++; if ({load_data, bus_if.addr, bus_if.wdata, bus_if.be} !== 100'h0) begin errors++; $display("FAIL rmw_data got=%h want=0", {load_data, bus_if.addr, bus_if.wdata, bus_if.be}); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads_ext();
        test_stores();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
